// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side bus of the RAM arbiter: two request/grant/read-return channels.
interface ram_arb_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them stable until it
    // sees gntN high; the operation is accepted on the rising edge that ends a gntN=1 cycle.
    // Reads return later as a one-cycle rvalidN pulse with rdataN; rdataN holds otherwise.
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );

endinterface

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker: combinational grant plus the registered priority pointer.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic ptr
);

    logic ptr_q;
    logic ptr_next;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Reset suppresses grants so nothing is accepted on the resetting edge.
        if (!reset) begin
            if (req0 && (!req1 || ptr_q == REQ0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_q;
        if (gnt0) begin
            ptr_next = REQ1;
        end else if (gnt1) begin
            ptr_next = REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_next;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM; registers the RAM controls and
// steers read data back to the issuing requester through a tag pipeline.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_arb_if.slave          bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              dbg_ptr
);

    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rd_tag_t           tag_pipe [RD_LATENCY+1];
    rd_tag_t           tag_out;

    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    ram_arb_rr2 u_rr2 (
        .clk   (clk),
        .reset (reset),
        .req0  (bus.req0),
        .req1  (bus.req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .ptr   (dbg_ptr)
    );

    assign gnt_any   = gnt0 | gnt1;
    assign sel_id    = gnt1 ? REQ1 : REQ0;
    assign sel_we    = gnt1 ? bus.we1    : bus.we0;
    assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
    assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

    // Address and data hold through idle cycles; only the write strobe drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (gnt_any) begin
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
        end else begin
            ram_we   <= 1'b0;
        end
    end

    // Stage k holds the tag of the read whose address has been on the RAM for k cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: gnt_any & ~sel_we, id: sel_id};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tag_out.valid && (tag_out.id == REQ0);
            rvalid1_q <= tag_out.valid && (tag_out.id == REQ1);
            if (tag_out.valid && (tag_out.id == REQ0)) begin
                rdata0_q <= ram_dout;
            end
            if (tag_out.valid && (tag_out.id == REQ1)) begin
                rdata1_q <= ram_dout;
            end
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port 1K x 8 `ram` (clk, write_enable, address[9:0], data_in[7:0], data_out[7:0]) between two requesters.
- Each requester issues read/write operations through a valid/ready handshake.
- The arbiter grants at most one operation per cycle, using round-robin priority when both request.
- It drives registered RAM controls and routes tagged read data back to the issuing requester.
- It sits directly in front of `ram`; nothing else may drive the RAM ports.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, cycles from ram_addr being driven to ram_dout being valid (range 0..3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 operation valid.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 operation accepted this cycle (combinational).
- rvalid0  out  1  requester 0 read data valid (registered).
- rdata0  out  DATA_W  requester 0 read data (registered).
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same for requester 1.
- ram_we  out  1  to ram write_enable (registered).
- ram_addr  out  ADDR_W  to ram address (registered).
- ram_din  out  DATA_W  to ram data_in (registered).
- ram_dout  in  DATA_W  from ram data_out.

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset takes effect on the clk edge where reset=1.
- Reset values:
  - gnt0/gnt1 = 0 while reset is high.
  - rvalid0/rvalid1 = 0, rdata0/rdata1 = 0.
  - ram_we = 0, ram_addr = 0, ram_din = 0.
  - Priority pointer = requester 0.
  - Read-tag pipeline cleared.
- Arbitration (combinational, cycle t):
  - Only req0 high: gnt0 = 1.
  - Only req1 high: gnt1 = 1.
  - Both high: grant the requester the pointer names.
  - Neither high: no grant.
  - gnt is never asserted without the matching req.
  - At most one gnt per cycle.
- Pointer:
  - After any grant to requester X, the pointer moves to the other requester.
  - With no grant, the pointer holds.
  - Under sustained contention, grants strictly alternate 0,1,0,1.
- Accept is the handshake: a requester holding req must keep we/addr/wdata stable until it sees gnt.
- RAM drive, cycle t+1 after a grant in cycle t:
  - ram_addr/ram_din = granted addr/wdata.
  - ram_we = granted we.
- Idle cycle: ram_we = 0; ram_addr and ram_din hold their last values.
- Read return:
  - A granted read pushes tag {valid=1, id} into a shift pipe of depth 1+RD_LATENCY.
  - ram_dout is sampled in cycle t+1+RD_LATENCY.
  - rvalid_id = 1 and rdata_id = ram_dout in cycle t+2+RD_LATENCY, for one cycle only. Default latency is 3 cycles from grant.
- rdata holds its last value when rvalid is low. The non-addressed requester's rvalid stays 0.
- Writes produce no response. A write is complete once ram_we has been driven.
- Ordering: operations reach the RAM in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
  - Back-to-back reads from alternating requesters return one per cycle, in order.
- Reset mid-operation: in-flight read tags are discarded, with no rvalid after reset, and any pending ram_we is cleared.
- Simultaneous reset and req: reset wins, no grant.

Decomposition:
- Package `ram_arb_pkg`: ADDR_W/DATA_W defaults, requester-id constants REQ0=0/REQ1=1, and the read-tag struct {valid, id}.
- Sub-module `ram_arb_rr2`: the two-way round-robin picker (req0, req1, pointer -> gnt0, gnt1, next pointer). It is combinational plus the pointer register.
- The tag pipeline and RAM drive registers live in the top module.

Test Plan:
- Write then read, single requester: req0 we0=1 addr0=55 wdata0=0x56, then req0 we0=0 addr0=55 -> gnt0 each cycle; ram_we=1 in cycle 1 with ram_addr=55, ram_din=0x56; rvalid0=1, rdata0=0x56 exactly 3 cycles after the read grant; rvalid1 stays 0.
- Contention alternation: req0 and req1 both held high for 6 cycles, reading addr 55 and 66 (preloaded 0x56/0x36) -> gnt pattern 0,1,0,1,0,1; rvalid0/rvalid1 alternate with rdata 0x56 and 0x36 respectively.
- Pointer fairness after idle: grant to 1 alone, one idle cycle, then both request -> gnt0 first, because the pointer moved to 0 and held through the idle cycle.
- Read-after-write hazard: requester 1 writes addr 66 = 0x36 and requester 0 reads addr 66 in the next cycle -> rdata0 = 0x36.
- Reset mid-flight: read granted in cycle t, reset high in cycle t+1 -> no rvalid in cycles t+1..t+5; ram_we=0; next contention grants requester 0 first.
- RD_LATENCY=2 build: single read of addr 55 -> rvalid0 in cycle t+4 with data 0x56.
